// File: rtl/source_char_streamer.sv
// source_char_streamer: walks ASCII text in a synchronous-read BRAM and emits normalised characters one at a time
//   Ports: clk_in/rst_in clock and sync active-high reset; start_in begins a pass from address 0; hold_in stalls new reads;
//   mem_addr_out/mem_data_in BRAM read port; valid_data/new_character/incoming_ascii character bus;
//   line_num 1-based source line; eof_flag end of text reached; busy streaming in progress.
module source_char_streamer #(
   parameter int ADDR_W       = 12,
   parameter int READ_LATENCY = 2,
   parameter int LINE_W       = 10
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   input  logic              hold_in,
   output logic [ADDR_W-1:0] mem_addr_out,
   input  logic [7:0]        mem_data_in,
   output logic              valid_data,
   output logic              new_character,
   output logic [7:0]        incoming_ascii,
   output logic [LINE_W-1:0] line_num,
   output logic              eof_flag,
   output logic              busy
);
   localparam int CW = $clog2(READ_LATENCY + 1);
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_EMIT, S_FLUSH, S_DONE} state_e;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [7:0]        byte_q, byte_d, char_q, char_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              in_comment_q, in_comment_d, last_nl_q, last_nl_d, flush_q, flush_d;
   logic              last_addr, drop;
   // the final address is never incremented past, so the stream cannot wrap to 0
   assign last_addr = addr_q == {ADDR_W{1'b1}};
   assign drop = (in_comment_q && byte_q != 8'h0A) || byte_q == "#" || byte_q == 8'h0D;
   always_ff @(posedge clk_in)
      if (rst_in) state_q <= S_IDLE;
      else state_q <= state_d;
   always_ff @(posedge clk_in)
      if (rst_in) begin
         addr_q       <= '0;
         mem_addr_q   <= '0;
         cnt_q        <= '0;
         byte_q       <= '0;
         char_q       <= '0;
         line_q       <= '0;
         in_comment_q <= 1'b0;
         last_nl_q    <= 1'b1;
         flush_q      <= 1'b0;
      end else begin
         addr_q       <= addr_d;
         mem_addr_q   <= mem_addr_d;
         cnt_q        <= cnt_d;
         byte_q       <= byte_d;
         char_q       <= char_d;
         line_q       <= line_d;
         in_comment_q <= in_comment_d;
         last_nl_q    <= last_nl_d;
         flush_q      <= flush_d;
      end
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      mem_addr_d   = addr_q;
      cnt_d        = cnt_q;
      byte_d       = byte_q;
      char_d       = char_q;
      line_d       = line_q;
      in_comment_d = in_comment_q;
      last_nl_d    = last_nl_q;
      flush_d      = flush_q;
      case (state_q)
         S_IDLE, S_DONE: if (start_in) begin
            addr_d       = '0;
            line_d       = LINE_W'(1);
            in_comment_d = 1'b0;
            last_nl_d    = 1'b1;
            flush_d      = 1'b0;
            state_d      = S_ISSUE;
         end
         S_ISSUE: if (!hold_in) begin
            cnt_d   = CW'(READ_LATENCY);
            state_d = S_WAIT;
         end
         // one extra cycle beyond the latency: the registered address lands a cycle after ISSUE
         S_WAIT: if (cnt_q == '0) begin
            byte_d  = mem_data_in;
            state_d = S_EVAL;
         end else cnt_d = cnt_q - CW'(1);
         S_EVAL: if (byte_q == 8'h00) state_d = S_FLUSH;
         else if (drop) begin
            in_comment_d = in_comment_q || byte_q == "#";
            addr_d       = last_addr ? addr_q : addr_q + ADDR_W'(1);
            state_d      = last_addr ? S_FLUSH : S_ISSUE;
         end else begin
            char_d       = byte_q == 8'h09 ? 8'h20 : byte_q;
            in_comment_d = byte_q == 8'h0A ? 1'b0 : in_comment_q;
            state_d      = S_EMIT;
         end
         S_EMIT: begin
            last_nl_d = char_q == 8'h0A;
            // the synthetic terminator from FLUSH does not advance the line count
            line_d    = !flush_q && char_q == 8'h0A && !(&line_q) ? line_q + LINE_W'(1) : line_q;
            addr_d    = flush_q || last_addr ? addr_q : addr_q + ADDR_W'(1);
            state_d   = flush_q ? S_DONE : last_addr ? S_FLUSH : S_ISSUE;
         end
         S_FLUSH: begin
            char_d  = last_nl_q ? char_q : 8'h0A;
            flush_d = !last_nl_q;
            state_d = last_nl_q ? S_DONE : S_EMIT;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_comb begin
      busy          = state_q != S_IDLE && state_q != S_DONE;
      valid_data    = busy;
      new_character = state_q == S_EMIT;
      eof_flag      = state_q == S_DONE;
   end
   assign mem_addr_out   = mem_addr_q;
   assign incoming_ascii = char_q;
   assign line_num       = line_q;
endmodule

// File: tb/tb_source_char_streamer.sv
// tb_source_char_streamer: table-driven and directed checks of source_char_streamer with ADDR_W=4, READ_LATENCY=2
module tb_source_char_streamer;
   localparam int L = 2;
   logic       clk = 1'b0, rst_in = 1'b1, start_in = 1'b0, hold_in = 1'b0;
   logic [3:0] mem_addr_out;
   logic [7:0] mem_data_in, incoming_ascii;
   logic [9:0] line_num;
   logic       valid_data, new_character, eof_flag, busy;
   logic [7:0] mem [16];
   logic [7:0] s0 = 8'h00, s1 = 8'h00;
   int         total = 0, bad = 0, cyc = 0;
   logic [7:0] q_ch [$];
   logic [9:0] q_ln [$];
   int         q_cy [$];
   typedef struct packed {
      logic [191:0] txt;
      logic [191:0] exp;
      logic [9:0]   line;
      logic [3:0]   addr;
   } vec_t;
   vec_t tbl [6];
   source_char_streamer #(.ADDR_W(4), .READ_LATENCY(L), .LINE_W(10)) dut (
      .clk_in(clk), .rst_in(rst_in), .start_in(start_in), .hold_in(hold_in),
      .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in), .valid_data(valid_data),
      .new_character(new_character), .incoming_ascii(incoming_ascii), .line_num(line_num),
      .eof_flag(eof_flag), .busy(busy));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      s0  <= mem[mem_addr_out];
      s1  <= s0;
      cyc <= cyc + 1;
   end
   assign mem_data_in = s1;
   always @(negedge clk)
      if (new_character) begin
         q_ch.push_back(incoming_ascii);
         q_ln.push_back(line_num);
         q_cy.push_back(cyc);
      end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic int vlen(input logic [191:0] v);
      int n = 0;
      for (int i = 0; i < 24; i++) if (v[i*8 +: 8] != 8'h00) n = i + 1;
      return n;
   endfunction
   function automatic logic [7:0] vchar(input logic [191:0] v, input int n, input int k);
      return v[(n-1-k)*8 +: 8];
   endfunction
   task automatic load(input logic [191:0] v);
      int n = vlen(v);
      for (int k = 0; k < 16; k++) mem[k] = k < n ? vchar(v, n, k) : 8'h00;
   endtask
   task automatic begin_run(output int c0);
      q_ch.delete();
      q_ln.delete();
      q_cy.delete();
      @(posedge clk); #1 start_in = 1'b1;
      @(posedge clk); #1 start_in = 1'b0;
      c0 = cyc;
   endtask
   task automatic finish_check(input string nm, input logic [191:0] e, input logic [9:0] ln,
                               input logic [3:0] ad, input int mingap);
      int t = 0, n = vlen(e), mg = 1000;
      logic [9:0] el = 10'd1;
      while (!eof_flag && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      chk({nm, " eof"}, 32'(eof_flag), 32'd1);
      chk({nm, " count"}, q_ch.size(), n);
      for (int k = 0; k < n && k < q_ch.size(); k++) begin
         chk($sformatf("%s char%0d", nm, k), 32'(q_ch[k]), 32'(vchar(e, n, k)));
         chk($sformatf("%s line%0d", nm, k), 32'(q_ln[k]), 32'(el));
         if (vchar(e, n, k) == 8'h0A) el++;
      end
      for (int k = 1; k < q_cy.size(); k++) if (q_cy[k] - q_cy[k-1] < mg) mg = q_cy[k] - q_cy[k-1];
      chk({nm, " gap_ok"}, 32'(mg >= mingap), 32'd1);
      chk({nm, " line_num"}, 32'(line_num), 32'(ln));
      chk({nm, " addr"}, 32'(mem_addr_out), 32'(ad));
      chk({nm, " busy_valid"}, {busy, valid_data}, 32'd0);
   endtask
   initial begin
      int c0, t;
      logic [191:0] full;
      tbl[0] = '{192'("addi x1,0x1F\n"), 192'("addi x1,0x1F\n"), 10'd2, 4'd13};
      tbl[1] = '{192'("li\t0x5 # c\n"),  192'("li 0x5 \n"),      10'd2, 4'd11};
      tbl[2] = '{192'("nop"),             192'("nop\n"),          10'd1, 4'd3};
      tbl[3] = '{192'("a\r\nb"),          192'("a\nb\n"),         10'd2, 4'd4};
      tbl[4] = '{192'("#x\nq"),           192'("\nq\n"),          10'd2, 4'd4};
      tbl[5] = '{192'(""),                192'(""),               10'd1, 4'd0};
      for (int k = 0; k < 16; k++) mem[k] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset outputs", {mem_addr_out, valid_data, new_character, incoming_ascii, line_num, eof_flag, busy}, 32'd0);
      rst_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         load(tbl[i].txt);
         begin_run(c0);
         finish_check($sformatf("vec%0d", i), tbl[i].exp, tbl[i].line, tbl[i].addr, L + 3);
      end
      // first-character latency, eof clearing, then a 20-cycle hold after the first pulse
      load(192'("addi x1,0x1F\n"));
      begin_run(c0);
      chk("restart flags", {eof_flag, valid_data, busy}, 32'b011);
      t = 0;
      while (!new_character && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("first latency", cyc - c0, L + 3);
      hold_in = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("hold addr", 32'(mem_addr_out), 32'd1);
      chk("hold pulses", q_ch.size(), 32'd1);
      hold_in = 1'b0;
      finish_check("hold", 192'("addi x1,0x1F\n"), 10'd2, 4'd13, L + 3);
      // reset while a read is in flight
      begin_run(c0);
      repeat (2) @(posedge clk);
      #1 rst_in = 1'b1;
      @(posedge clk); #1;
      chk("midreset outputs", {mem_addr_out, valid_data, new_character, incoming_ascii, line_num, eof_flag, busy}, 32'd0);
      rst_in = 1'b0;
      begin_run(c0);
      chk("restart line", 32'(line_num), 32'd1);
      chk("restart addr", 32'(mem_addr_out), 32'd0);
      finish_check("restart", 192'("addi x1,0x1F\n"), 10'd2, 4'd13, L + 3);
      // memory with no terminator: stops at the last address, no wrap
      for (int k = 0; k < 16; k++) mem[k] = 8'h7A;
      full = 192'("zzzzzzzzzzzzzzzz\n");
      begin_run(c0);
      finish_check("full", full, 10'd1, 4'd15, 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
